// File: rtl/flag_cond_stage.sv
// flag_cond_stage
// One-entry pipeline register between the ALU and writeback. It evaluates an
// ARM-style condition code against a committed {N,Z,C,V} flag register. It
// gates the register write enable with the condition result, optionally
// commits new flags, and counts items whose condition failed (saturating).
// Flags committed by one item are seen by the very next accepted item with no
// bubble, because the condition of an incoming item is always evaluated
// against the registered flags, which are updated on that item's accept edge.
module flag_cond_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    // upstream handshake and payload
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              z,
    input  logic              n,
    input  logic              c,
    input  logic              v,
    input  logic              set_flags,
    input  logic [3:0]        cond,
    input  logic [3:0]        rd,
    input  logic              wr_en,
    // downstream handshake and payload
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        wb_rd,
    output logic              wb_we,
    // architectural state
    output logic [3:0]        flags,
    output logic [CNT_W-1:0]  squash_cnt
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Flag register bit positions inside {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

    stage_state_t      state_reg;
    stage_state_t      state_next;

    logic [DATA_W-1:0] wb_data_reg;
    logic [DATA_W-1:0] wb_data_next;
    logic [3:0]        wb_rd_reg;
    logic [3:0]        wb_rd_next;
    logic              wb_we_reg;
    logic              wb_we_next;
    logic [3:0]        flags_reg;
    logic [3:0]        flags_next;
    logic [CNT_W-1:0]  squash_cnt_reg;
    logic [CNT_W-1:0]  squash_cnt_next;

    // Handshake terms
    logic              full;
    logic              accept;
    logic              drain;

    // Condition evaluation
    logic [15:0]       cond_table;
    logic              cond_pass;
    logic              commit_flags;
    logic              squash;
    logic              squash_saturated;

    // ------------------------------------------------------------------
    // Condition evaluator for a single code against a flag snapshot.
    // Written as an explicit table so each row reads like the ISA manual.
    // ------------------------------------------------------------------
    function automatic logic cond_eval(input logic [3:0] code,
                                       input logic [3:0] f);
        logic fn;
        logic fz;
        logic fc;
        logic fv;
        logic result;
        fn = f[FLAG_N];
        fz = f[FLAG_Z];
        fc = f[FLAG_C];
        fv = f[FLAG_V];
        result = 1'b0;
        case (code)
            4'b0000: result = fz;                       // EQ
            4'b0001: result = ~fz;                      // NE
            4'b0010: result = fc;                       // CS/HS
            4'b0011: result = ~fc;                      // CC/LO
            4'b0100: result = fn;                       // MI
            4'b0101: result = ~fn;                      // PL
            4'b0110: result = fv;                       // VS
            4'b0111: result = ~fv;                      // VC
            4'b1000: result = fc & ~fz;                 // HI
            4'b1001: result = ~fc | fz;                 // LS
            4'b1010: result = (fn == fv);               // GE
            4'b1011: result = (fn != fv);               // LT
            4'b1100: result = ~fz & (fn == fv);         // GT
            4'b1101: result = fz | (fn != fv);          // LE
            4'b1110: result = 1'b1;                     // AL
            4'b1111: result = 1'b0;                     // NV
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    // ------------------------------------------------------------------
    // Evaluate all 16 condition codes in parallel against the committed
    // flags, then pick the one the incoming instruction asks for. This
    // keeps the cond -> cond_pass path a single 16:1 mux.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_cond
            localparam logic [3:0] CODE = 4'(gi);
            assign cond_table[gi] = cond_eval(CODE, flags_reg);
        end
    endgenerate

    assign cond_pass = cond_table[cond];

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign full     = (state_reg == ST_FULL);
    assign in_ready = ~full | out_ready;
    assign accept   = in_valid & in_ready;
    assign drain    = full & out_ready;

    // Flag commit and squash bookkeeping only happen on an accepted item
    assign commit_flags     = accept & set_flags & cond_pass;
    assign squash           = accept & ~cond_pass;
    assign squash_saturated = (squash_cnt_reg == CNT_MAX);

    // ------------------------------------------------------------------
    // Occupancy FSM register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Occupancy FSM next state: fill on accept, empty only on drain without
    // a replacement item arriving in the same cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (drain && !accept) begin
                    state_next = ST_EMPTY;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    // Payload next values: load on accept, otherwise hold so a stalled
    // output stays stable under backpressure
    always_comb begin
        wb_data_next = wb_data_reg;
        wb_rd_next   = wb_rd_reg;
        wb_we_next   = wb_we_reg;
        if (accept) begin
            wb_data_next = alu_out;
            wb_rd_next   = rd;
            wb_we_next   = wr_en & cond_pass;
        end
    end

    // Flag register and squash counter next values
    always_comb begin
        flags_next      = flags_reg;
        squash_cnt_next = squash_cnt_reg;
        if (commit_flags) begin
            flags_next = {n, z, c, v};
        end
        if (squash && !squash_saturated) begin
            squash_cnt_next = squash_cnt_reg + CNT_ONE;
        end
    end

    // Payload, flag and counter registers; reset discards any in-flight item
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_data_reg    <= '0;
            wb_rd_reg      <= '0;
            wb_we_reg      <= 1'b0;
            flags_reg      <= 4'b0000;
            squash_cnt_reg <= '0;
        end else begin
            wb_data_reg    <= wb_data_next;
            wb_rd_reg      <= wb_rd_next;
            wb_we_reg      <= wb_we_next;
            flags_reg      <= flags_next;
            squash_cnt_reg <= squash_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid  = full;
    assign wb_data    = wb_data_reg;
    assign wb_rd      = wb_rd_reg;
    assign wb_we      = wb_we_reg;
    assign flags      = flags_reg;
    assign squash_cnt = squash_cnt_reg;

endmodule

// File: doc/flag_cond_stage.md
FLAG_COND_STAGE -- requirements
Module: flag_cond_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of the ALU result and writeback data.
REQ-002 Parameter CNT_W, default 16, width of the squash counter.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-low reset; sampled on rising clk.
REQ-006 in_valid  input  1  upstream ALU result and flags are valid.
REQ-007 in_ready  output  1  stage can accept the upstream item this cycle.
REQ-008 alu_out  input  DATA_W  ALU result.
REQ-009 z, n, c, v  input  1 each  ALU flags for alu_out.
REQ-010 set_flags  input  1  instruction requests a flag-register update.
REQ-011 cond  input  4  ARM-style condition code of the incoming instruction.
REQ-012 rd  input  4  destination register index.
REQ-013 wr_en  input  1  instruction writes rd.
REQ-014 out_valid  output  1  output register holds a valid item.
REQ-015 out_ready  input  1  downstream accepts the item this cycle.
REQ-016 wb_data  output  DATA_W  registered result.
REQ-017 wb_rd  output  4  registered destination index.
REQ-018 wb_we  output  1  registered write enable, gated by the condition result.
REQ-019 flags  output  4  committed flag register {N,Z,C,V}.
REQ-020 squash_cnt  output  CNT_W  count of accepted items whose condition failed.

Function
REQ-021 accept = in_valid & in_ready; drain = out_valid & out_ready.
REQ-022 The stage is a one-entry pipeline register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-023 in_ready = ~out_valid | out_ready, combinationally; the stage accepts and drains in the same cycle when FULL and out_ready=1.
REQ-024 Transitions: EMPTY+accept->FULL; FULL+drain+~accept->EMPTY; FULL+drain+accept->FULL with the new item; FULL+~drain->FULL with output held stable.
REQ-025 cond_pass is combinational from cond and the current flags register: 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0.
REQ-026 On accept: wb_data<=alu_out, wb_rd<=rd, wb_we<=wr_en&cond_pass, out_valid<=1, all in one cycle.
REQ-027 On accept with set_flags=1 and cond_pass=1: flags<={n,z,c,v} in the same edge; otherwise flags hold.
REQ-028 The next accepted item evaluates its condition against the updated flags (zero-bubble back-to-back forwarding through the flag register).
REQ-029 On accept with cond_pass=0: squash_cnt increments by 1 and saturates at all-ones; the item still passes downstream with wb_we=0.
REQ-030 Without accept, flags and squash_cnt hold; in_valid, set_flags and cond are ignored.
REQ-031 Latency is exactly 1 cycle from accept to out_valid; throughput is 1 item per cycle while out_ready=1.
REQ-032 While FULL and out_ready=0, wb_data, wb_rd and wb_we remain constant.

Reset
REQ-033 When rst=0 at a rising edge: out_valid=0, wb_data=0, wb_rd=0, wb_we=0, flags=4'b0000, squash_cnt=0.
REQ-034 Reset overrides accept and drain in the same cycle; an in-flight item is discarded.
REQ-035 in_ready=1 in the first cycle after reset deassertion.

Verification
REQ-036 After reset: accept alu_out=0, z=1, set_flags=1, cond=1110 -> next cycle flags=4'b0100, wb_we=wr_en, out_valid=1.
REQ-037 Back-to-back: item A (set_flags=1, z=1, cond=1110), then item B (cond=0000, wr_en=1) in the next cycle -> B wb_we=1; repeat with B cond=0001 -> wb_we=0, squash_cnt+1.
REQ-038 Backpressure: FULL, out_ready=0 for 3 cycles, in_valid=1 -> in_ready=0, outputs stable, flags unchanged; then out_ready=1 -> drain and accept in the same edge.
REQ-039 Failed condition with set_flags=1 (cond=1111, n=1) -> flags unchanged, wb_we=0, squash_cnt increments.
REQ-040 Saturation and reset: force 2^CNT_W squashes -> squash_cnt holds at all-ones; rst=0 while FULL -> all outputs return to reset values the next cycle.
REQ-041 Condition table sweep: for all 16 flag values x 16 cond codes -> wb_we matches REQ-025.
